// File: rtl/fast_cmd_pkg.sv
// Shared definitions for the ngCCM fast-control command sequencer:
// default orbit length, command encoding, FSM state encoding and the
// fixed-priority command picker.
package fast_cmd_pkg;

    // LHC bunch crossings per orbit
    localparam int ORBIT_LEN_DEFAULT = 3564;

    // Command identifiers, also used as the "which output is on the wire" tag
    typedef enum logic [1:0] {
        CMD_NONE = 2'd0,
        CMD_QIE  = 2'd1,
        CMD_WTE  = 2'd2,
        CMD_AUX  = 2'd3
    } cmd_t;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // Fixed priority: QIE reset beats WTE beats AUX
    function automatic cmd_t pick_cmd(input logic qie, input logic wte, input logic aux);
        cmd_t result;
        result = CMD_NONE;
        if (qie) begin
            result = CMD_QIE;
        end else if (wte) begin
            result = CMD_WTE;
        end else if (aux) begin
            result = CMD_AUX;
        end
        return result;
    endfunction

endpackage

// File: rtl/fast_cmd_sequencer_req_sync_edge.sv
// Two-flop synchroniser for an asynchronous front-panel level followed by
// an edge detector. The strobe is one clk wide and is valid in the third
// cycle after the input edge (sync1, sync2, then compare against prev).
module req_sync_edge #(
    parameter bit FALLING = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic strobe
);

    logic sync1;
    logic sync2;
    logic prev;

    // Metastability chain plus one history flop for the edge compare
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= level;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // Flops clear to 0, so an input that idles high after reset produces
    // a rising edge but never a spurious falling one.
    assign strobe = FALLING ? (prev & ~sync2) : (sync2 & ~prev);

endmodule

// File: rtl/fast_cmd_sequencer.sv
// Fast-control command sequencer for the ngCCM emulator. Keeps the BX and
// orbit counters, turns manual and scheduled requests into one-deep pending
// flags, and issues them one at a time as fixed-length pulses separated by
// a minimum idle gap.
module fast_cmd_sequencer
    import fast_cmd_pkg::*;
#(
    parameter int ORBIT_LEN = ORBIT_LEN_DEFAULT,
    parameter int BX_W      = 12,
    parameter int PULSE_LEN = 2,
    parameter int GAP_LEN   = 4
) (
    input  logic            clk_in,
    input  logic            reset_in,
    input  logic            enable,
    input  logic            mode_select,
    input  logic            qie_reset_req,
    input  logic            wte_req,
    input  logic            aux_req,
    input  logic [BX_W-1:0] qie_reset_bx,
    input  logic [BX_W-1:0] wte_bx,
    input  logic [7:0]      orbit_period,
    output logic [BX_W-1:0] bx_count,
    output logic [15:0]     orbit_count,
    output logic            qie_reset_out,
    output logic            wte_out,
    output logic            aux_out,
    output logic            busy,
    output state_t          state_dbg
);

    localparam logic [BX_W-1:0] BX_LAST = BX_W'(ORBIT_LEN - 1);
    localparam int CNT_MAX = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_LEN == 0) ? 0 : GAP_LEN - 1);

    // Manual request strobes
    logic qie_edge;
    logic wte_edge;
    logic aux_edge;

    // Orbit-period counter for the scheduled QIE reset
    logic [7:0] period_cnt;

    // One-deep pending flags
    logic pend_qie;
    logic pend_wte;
    logic pend_aux;

    // Request sources after mode selection
    logic set_qie;
    logic set_wte;
    logic set_aux;
    logic sched_qie;
    logic sched_wte;
    logic bx_wrap;

    // FSM
    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    cmd_t             cur_cmd;
    cmd_t             cur_next;
    cmd_t             candidate;
    cmd_t             grant;
    logic             issue;

    req_sync_edge #(.FALLING(1'b0)) u_qie_sync (
        .clk    (clk_in),
        .rst    (reset_in),
        .level  (qie_reset_req),
        .strobe (qie_edge)
    );

    req_sync_edge #(.FALLING(1'b0)) u_wte_sync (
        .clk    (clk_in),
        .rst    (reset_in),
        .level  (wte_req),
        .strobe (wte_edge)
    );

    // AUX idles high; the request is the falling edge
    req_sync_edge #(.FALLING(1'b1)) u_aux_sync (
        .clk    (clk_in),
        .rst    (reset_in),
        .level  (aux_req),
        .strobe (aux_edge)
    );

    assign bx_wrap = (bx_count == BX_LAST);

    // BX, orbit and orbit-period counters; all held at zero while disabled
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            bx_count    <= '0;
            orbit_count <= '0;
            period_cnt  <= '0;
        end else if (!enable) begin
            bx_count    <= '0;
            orbit_count <= '0;
            period_cnt  <= '0;
        end else if (bx_wrap) begin
            bx_count    <= '0;
            orbit_count <= orbit_count + 16'd1;
            if (orbit_period != 8'd0) begin
                if (period_cnt >= orbit_period - 8'd1) begin
                    period_cnt <= '0;
                end else begin
                    period_cnt <= period_cnt + 8'd1;
                end
            end
        end else begin
            bx_count <= bx_count + BX_W'(1);
        end
    end

    // Scheduled matches. bx_count never reaches ORBIT_LEN, so a programmed
    // BX at or beyond the orbit length can never match.
    assign sched_wte = (bx_count == wte_bx);
    assign sched_qie = (bx_count == qie_reset_bx) && (orbit_period != 8'd0)
                    && (period_cnt == orbit_period - 8'd1);

    // Manual QIE/WTE only in manual mode, scheduled only in scheduled mode;
    // AUX is always manual.
    assign set_qie = mode_select ? sched_qie : qie_edge;
    assign set_wte = mode_select ? sched_wte : wte_edge;
    assign set_aux = aux_edge;

    // Pending flags: a new strobe wins over a grant clearing the same flag,
    // and a strobe on an already-set flag merges into it.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            pend_qie <= 1'b0;
            pend_wte <= 1'b0;
            pend_aux <= 1'b0;
        end else if (!enable) begin
            pend_qie <= 1'b0;
            pend_wte <= 1'b0;
            pend_aux <= 1'b0;
        end else begin
            pend_qie <= (pend_qie & (grant != CMD_QIE)) | set_qie;
            pend_wte <= (pend_wte & (grant != CMD_WTE)) | set_wte;
            pend_aux <= (pend_aux & (grant != CMD_AUX)) | set_aux;
        end
    end

    assign candidate = pick_cmd(pend_qie, pend_wte, pend_aux);

    // Next-state logic. The end of a GAP (or of a PULSE when there is no
    // gap) is itself an issue point, so back-to-back commands are spaced
    // exactly PULSE_LEN+GAP_LEN clk apart.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        cur_next   = cur_cmd;
        grant      = CMD_NONE;
        issue      = 1'b0;

        case (state)
            ST_IDLE: begin
                issue = 1'b1;
            end
            ST_PULSE: begin
                if (cnt == PULSE_LAST) begin
                    if (GAP_LEN == 0) begin
                        issue = 1'b1;
                    end else begin
                        state_next = ST_GAP;
                        cnt_next   = '0;
                        cur_next   = CMD_NONE;
                    end
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt == GAP_LAST) begin
                    issue = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
                cur_next   = CMD_NONE;
            end
        endcase

        if (issue) begin
            if (candidate != CMD_NONE) begin
                grant      = candidate;
                state_next = ST_PULSE;
                cnt_next   = '0;
                cur_next   = candidate;
            end else begin
                state_next = ST_IDLE;
                cnt_next   = '0;
                cur_next   = CMD_NONE;
            end
        end

        // Disable aborts any pulse and parks the sequencer
        if (!enable) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
            cur_next   = CMD_NONE;
            grant      = CMD_NONE;
        end
    end

    // State register and registered, one-hot command outputs
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            cur_cmd       <= CMD_NONE;
            qie_reset_out <= 1'b0;
            wte_out       <= 1'b0;
            aux_out       <= 1'b1;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            cur_cmd       <= cur_next;
            qie_reset_out <= (cur_next == CMD_QIE);
            wte_out       <= (cur_next == CMD_WTE);
            aux_out       <= (cur_next != CMD_AUX);
        end
    end

    assign busy      = (state != ST_IDLE) | pend_qie | pend_wte | pend_aux;
    assign state_dbg = state;

endmodule

// File: tb/tb_fast_cmd_sequencer.sv
// Bench for fast_cmd_sequencer (ORBIT_LEN=20, PULSE_LEN=2, GAP_LEN=4).
// A timeline model (edge index, pulse/busy end times, pending bits, input
// history) predicts every output each cycle; directed scenarios add
// hand-computed timing checks.
module tb_fast_cmd_sequencer;
    import fast_cmd_pkg::*;

    localparam int L   = 20;
    localparam int BXW = 5;
    localparam int P   = 2;
    localparam int G   = 4;

    // Clock / reset / stimulus
    logic           clk           = 1'b0;
    logic           rst           = 1'b0;
    logic           enable        = 1'b0;
    logic           mode_select   = 1'b0;
    logic           qie_reset_req = 1'b0;
    logic           wte_req       = 1'b0;
    logic           aux_req       = 1'b1;
    logic [BXW-1:0] qie_reset_bx  = 5'd31;
    logic [BXW-1:0] wte_bx        = 5'd31;
    logic [7:0]     orbit_period  = 8'd0;

    logic [BXW-1:0] bx_count;
    logic [15:0]    orbit_count;
    logic           qie_reset_out;
    logic           wte_out;
    logic           aux_out;
    logic           busy;
    state_t         state_dbg;

    always #5 clk = ~clk;

    fast_cmd_sequencer #(
        .ORBIT_LEN (L),
        .BX_W      (BXW),
        .PULSE_LEN (P),
        .GAP_LEN   (G)
    ) dut (
        .clk_in        (clk),
        .reset_in      (rst),
        .enable        (enable),
        .mode_select   (mode_select),
        .qie_reset_req (qie_reset_req),
        .wte_req       (wte_req),
        .aux_req       (aux_req),
        .qie_reset_bx  (qie_reset_bx),
        .wte_bx        (wte_bx),
        .orbit_period  (orbit_period),
        .bx_count      (bx_count),
        .orbit_count   (orbit_count),
        .qie_reset_out (qie_reset_out),
        .wte_out       (wte_out),
        .aux_out       (aux_out),
        .busy          (busy),
        .state_dbg     (state_dbg)
    );

    // ---------------- model ----------------
    int cyc = 0;            // index of most recent posedge
    int m_n = 0;            // enabled clocks since counters were cleared
    int m_out_until = 0;    // output active while cyc < m_out_until
    int m_busy_until = 0;   // PULSE/GAP while cyc < m_busy_until
    int m_cmd = 0;          // 1 qie, 2 wte, 3 aux
    bit m_pq = 0, m_pw = 0, m_pa = 0;
    bit [2:0] m_hq = 0, m_hw = 0, m_ha = 0;   // [0] newest input sample
    bit m_sq, m_sw, m_sa;
    int m_bx, m_orb;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_n = 0; m_out_until = 0; m_busy_until = 0; m_cmd = 0;
            m_pq = 0; m_pw = 0; m_pa = 0;
            m_hq = 0; m_hw = 0; m_ha = 0;
        end else begin
            cyc++;
            m_sq = 0; m_sw = 0; m_sa = 0;
            if (enable) begin
                m_bx  = m_n % L;
                m_orb = m_n / L;
                if (mode_select) begin
                    m_sw = (int'(wte_bx) < L) && (int'(wte_bx) == m_bx);
                    m_sq = (int'(qie_reset_bx) < L) && (int'(qie_reset_bx) == m_bx)
                        && (orbit_period != 8'd0)
                        && ((m_orb % int'(orbit_period)) == int'(orbit_period) - 1);
                end else begin
                    // input rose between the samples taken 3 and 2 edges ago
                    m_sq = m_hq[1] & ~m_hq[2];
                    m_sw = m_hw[1] & ~m_hw[2];
                end
                m_sa = ~m_ha[1] & m_ha[2];
                if (cyc >= m_busy_until && (m_pq || m_pw || m_pa)) begin
                    if (m_pq) begin m_cmd = 1; m_pq = 0; end
                    else if (m_pw) begin m_cmd = 2; m_pw = 0; end
                    else begin m_cmd = 3; m_pa = 0; end
                    m_out_until  = cyc + P;
                    m_busy_until = cyc + P + G;
                end
                m_pq = m_pq | m_sq;
                m_pw = m_pw | m_sw;
                m_pa = m_pa | m_sa;
                m_n++;
            end else begin
                m_n = 0; m_out_until = 0; m_busy_until = 0; m_cmd = 0;
                m_pq = 0; m_pw = 0; m_pa = 0;
            end
            m_hq = {m_hq[1:0], qie_reset_req};
            m_hw = {m_hw[1:0], wte_req};
            m_ha = {m_ha[1:0], aux_req};
        end
    end

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // pulse monitors (written only from tick)
    int q_starts = 0, w_starts = 0, a_starts = 0;
    int q_hi = 0, w_hi = 0, a_lo = 0;
    int q_last = 0, w_last = 0, a_last = 0;
    int q_last_bx = 0, q_last_orb = 0, w_last_bx = 0;
    int busy_fall = 0;
    logic pq_prev = 1'b0, pw_prev = 1'b0, pa_prev = 1'b1, pb_prev = 1'b0;

    task automatic tick();
        bit act_q, act_w, act_a;
        @(negedge clk);
        act_q = (cyc < m_out_until) && (m_cmd == 1);
        act_w = (cyc < m_out_until) && (m_cmd == 2);
        act_a = (cyc < m_out_until) && (m_cmd == 3);
        chk("bx_count",      32'(bx_count),    32'(m_n % L));
        chk("orbit_count",   32'(orbit_count), 32'((m_n / L) % 65536));
        chk("qie_reset_out", 32'(qie_reset_out), 32'(act_q));
        chk("wte_out",       32'(wte_out),       32'(act_w));
        chk("aux_out",       32'(aux_out),       32'(!act_a));
        chk("busy",          32'(busy), 32'((cyc < m_busy_until) || m_pq || m_pw || m_pa));
        if (qie_reset_out && !pq_prev) begin
            q_starts++; q_last = cyc; q_last_bx = int'(bx_count); q_last_orb = int'(orbit_count);
        end
        if (wte_out && !pw_prev) begin
            w_starts++; w_last = cyc; w_last_bx = int'(bx_count);
        end
        if (!aux_out && pa_prev) begin
            a_starts++; a_last = cyc;
        end
        if (qie_reset_out) q_hi++;
        if (wte_out) w_hi++;
        if (!aux_out) a_lo++;
        if (!busy && pb_prev) busy_fall = cyc;
        pq_prev = qie_reset_out; pw_prev = wte_out; pa_prev = aux_out; pb_prev = busy;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int c, q0, w0, a0, qh0, wh0, al0;

        #1 rst = 1'b1;
        ticks(3);
        chk("reset_state_idle", 32'(state_dbg), 32'(ST_IDLE));
        chk("reset_aux_high",   32'(aux_out),   32'd1);
        chk("reset_busy_low",   32'(busy),      32'd0);
        rst = 1'b0;
        ticks(2);

        // Manual WTE in mode 0: pulse 2 clk wide, 4 clk after the edge
        enable = 1'b1;
        ticks(5);
        q0 = q_starts; w0 = w_starts; a0 = a_starts; wh0 = w_hi;
        c = cyc;
        wte_req = 1'b1;
        ticks(12);
        chk("t2_wte_count",   32'(w_starts - w0), 32'd1);
        chk("t2_wte_latency", 32'(w_last - c),    32'd4);
        chk("t2_wte_width",   32'(w_hi - wh0),    32'd2);
        chk("t2_no_qie",      32'(q_starts - q0), 32'd0);
        chk("t2_no_aux",      32'(a_starts - a0), 32'd0);
        wte_req = 1'b0;
        ticks(6);

        // Async reset in the middle of a QIE pulse
        qie_reset_req = 1'b1;
        ticks(4);
        chk("t1_qie_before_rst", 32'(qie_reset_out), 32'd1);
        #2 rst = 1'b1;
        qie_reset_req = 1'b0;
        #1;
        chk("t1_rst_qie",   32'(qie_reset_out), 32'd0);
        chk("t1_rst_wte",   32'(wte_out),       32'd0);
        chk("t1_rst_aux",   32'(aux_out),       32'd1);
        chk("t1_rst_busy",  32'(busy),          32'd0);
        chk("t1_rst_bx",    32'(bx_count),      32'd0);
        chk("t1_rst_orbit", 32'(orbit_count),   32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("t1_bx_after_release", 32'(bx_count), 32'd0);
        ticks(12);

        // AUX fall and QIE rise together: QIE first, AUX 6 clk later
        q0 = q_starts; a0 = a_starts; al0 = a_lo;
        c = cyc;
        aux_req = 1'b0;
        qie_reset_req = 1'b1;
        ticks(20);
        chk("t4_qie_latency", 32'(q_last - c),    32'd4);
        chk("t4_aux_latency", 32'(a_last - c),    32'd10);
        chk("t4_aux_count",   32'(a_starts - a0), 32'd1);
        chk("t4_aux_width",   32'(a_lo - al0),    32'd2);
        aux_req = 1'b1;
        qie_reset_req = 1'b0;
        ticks(8);

        // WTE re-requested twice while busy: merged into one extra pulse
        w0 = w_starts;
        c = cyc;
        wte_req = 1'b1;
        ticks(2);
        wte_req = 1'b0; tick();
        wte_req = 1'b1; tick();
        wte_req = 1'b0; tick();
        wte_req = 1'b1;
        ticks(20);
        chk("t5_wte_count",    32'(w_starts - w0), 32'd2);
        chk("t5_second_start", 32'(w_last - c),    32'd10);
        chk("t5_busy_fall",    32'(busy_fall - c), 32'd16);
        wte_req = 1'b0;
        ticks(6);

        // Enable dropped during a QIE pulse with WTE pending
        q0 = q_starts; w0 = w_starts;
        qie_reset_req = 1'b1;
        wte_req = 1'b1;
        ticks(4);
        chk("t6_qie_on",  32'(qie_reset_out), 32'd1);
        chk("t6_busy_on", 32'(busy),          32'd1);
        enable = 1'b0;
        tick();
        chk("t6_qie_off",  32'(qie_reset_out), 32'd0);
        chk("t6_bx_zero",  32'(bx_count),      32'd0);
        chk("t6_busy_off", 32'(busy),          32'd0);
        enable = 1'b1;
        ticks(20);
        chk("t6_qie_count", 32'(q_starts - q0), 32'd1);
        chk("t6_no_wte",    32'(w_starts - w0), 32'd0);
        qie_reset_req = 1'b0;
        wte_req = 1'b0;
        ticks(4);

        // Scheduled mode: both at BX 10, QIE every 2nd orbit
        enable = 1'b0;
        tick();
        mode_select  = 1'b1;
        wte_bx       = 5'd10;
        qie_reset_bx = 5'd10;
        orbit_period = 8'd2;
        tick();
        q0 = q_starts; w0 = w_starts;
        enable = 1'b1;
        ticks(82);
        chk("t3_qie_count",   32'(q_starts - q0),  32'd2);
        chk("t3_wte_count",   32'(w_starts - w0),  32'd4);
        chk("t3_qie_bx",      32'(q_last_bx),      32'd12);
        chk("t3_qie_orbit",   32'(q_last_orb),     32'd3);
        chk("t3_wte_after",   32'(w_last - q_last), 32'd6);
        chk("t3_wte_bx",      32'(w_last_bx),      32'd18);

        // Out-of-orbit BX never matches; manual WTE ignored in mode 1
        q0 = q_starts; w0 = w_starts;
        wte_bx       = 5'd25;
        qie_reset_bx = 5'd25;
        wte_req      = 1'b1;
        ticks(45);
        chk("t3b_no_qie", 32'(q_starts - q0), 32'd0);
        chk("t3b_no_wte", 32'(w_starts - w0), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
